// File: rtl/systolic_feeder_if.sv
// Bundles the feeder's start/operand/stream/status signals between the
// controlling master (host side) and the feeder (slave side).
//
// Handshake: a request is a single cycle in which start=1 and ready=1. The
// operands A_mat/B_mat are sampled on that cycle only. start while ready=0
// has no effect, so holding start high simply re-requests at the next ready
// cycle. done is a one-cycle pulse marking the cycle in which the array's
// accumulators hold the finished product.
interface systolic_feeder_if #(
  parameter int N = 8,
  parameter int W = 32
);
  logic                         start;
  logic [N-1:0][N-1:0][W-1:0]   A_mat;
  logic [N-1:0][N-1:0][W-1:0]   B_mat;
  logic                         ready;
  logic                         array_reset;
  logic [N-1:0][W-1:0]          A_out;
  logic [N-1:0][W-1:0]          B_out;
  logic                         busy;
  logic                         done;

  modport master (
    output start, A_mat, B_mat,
    input  ready, array_reset, A_out, B_out, busy, done
  );

  modport slave (
    input  start, A_mat, B_mat,
    output ready, array_reset, A_out, B_out, busy, done
  );
endinterface

// File: rtl/systolic_feeder.sv
// Skewed operand feeder for an N x N output-stationary systolic array.
// Captures A and B on an accepted start, clears the array for one cycle,
// streams row-skewed A and column-skewed B for 2N-1 cycles, waits N cycles
// for the last products to ripple through, then pulses done.
module systolic_feeder #(
  parameter int N = 8,
  parameter int W = 32
) (
  input  logic             clock,
  input  logic             reset,
  systolic_feeder_if.slave bus,
  output logic [2:0]       o_state
);

  localparam int CW = $clog2(2 * N) + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_FEED  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // Last step index of FEED (t = 2N-2) and of DRAIN (N cycles, 0..N-1).
  localparam logic [CW-1:0] FEED_LAST  = CW'(2 * N - 2);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(N - 1);

  logic [2:0]                 r_state;
  logic [CW-1:0]              r_t;
  logic [N-1:0][N-1:0][W-1:0] r_a;
  logic [N-1:0][N-1:0][W-1:0] r_b;

  logic [N-1:0][W-1:0]        w_a_out;
  logic [N-1:0][W-1:0]        w_b_out;

  // Sequencer: state, shared step counter and operand capture.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_t     <= '0;
      r_a     <= '0;
      r_b     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_a     <= bus.A_mat;
            r_b     <= bus.B_mat;
            r_t     <= '0;
            r_state <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          r_t     <= '0;
          r_state <= S_FEED;
        end
        S_FEED: begin
          if (r_t == FEED_LAST) begin
            r_t     <= '0;
            r_state <= S_DRAIN;
          end else begin
            r_t <= r_t + CW'(1);
          end
        end
        S_DRAIN: begin
          if (r_t == DRAIN_LAST) begin
            r_t     <= '0;
            r_state <= S_DONE;
          end else begin
            r_t <= r_t + CW'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_t     <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Skew network: at step t, row r carries A[r][t-r] and column c carries
  // B[t-c][c]; lanes whose index falls outside 0..N-1 stay zero. Outputs are
  // forced to zero while reset is held so the array sees no stale data.
  always_comb begin
    w_a_out = '0;
    w_b_out = '0;
    if (!reset && r_state == S_FEED) begin
      for (int r = 0; r < N; r++) begin
        for (int k = 0; k < N; k++) begin
          if (r_t == CW'(r + k)) begin
            w_a_out[r] = r_a[r][k];
            w_b_out[r] = r_b[k][r];
          end
        end
      end
    end
  end

  assign bus.A_out       = w_a_out;
  assign bus.B_out       = w_b_out;
  assign bus.ready       = !reset && (r_state == S_IDLE);
  assign bus.busy        = !reset && ((r_state == S_CLEAR) ||
                                      (r_state == S_FEED)  ||
                                      (r_state == S_DRAIN));
  assign bus.done        = !reset && (r_state == S_DONE);
  assign bus.array_reset = reset || (r_state == S_CLEAR);
  assign o_state         = r_state;

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder: an N=2 instance driving a small
// behavioural 2x2 output-stationary array, plus an N=1 instance driving a
// single MAC. Cycle numbers in comments count from the start-accept cycle.
module tb_systolic_feeder;
  localparam int W = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] st2;
  logic [2:0] st1;

  always #5 clk = ~clk;

  systolic_feeder_if #(.N(2), .W(W)) if2 ();
  systolic_feeder_if #(.N(1), .W(W)) if1 ();

  systolic_feeder #(.N(2), .W(W)) dut2 (
    .clock   (clk),
    .reset   (rst),
    .bus     (if2.slave),
    .o_state (st2)
  );

  systolic_feeder #(.N(1), .W(W)) dut1 (
    .clock   (clk),
    .reset   (rst),
    .bus     (if1.slave),
    .o_state (st1)
  );

  // 2x2 array: A moves right, B moves down, each PE accumulates a*b mod 2^W.
  logic [W-1:0] acc2 [2][2];
  logic [W-1:0] a_pipe [2];
  logic [W-1:0] b_pipe [2];
  logic [W-1:0] acc1;

  always_ff @(posedge clk) begin
    if (if2.array_reset) begin
      for (int i = 0; i < 2; i++) begin
        a_pipe[i] <= '0;
        b_pipe[i] <= '0;
        for (int j = 0; j < 2; j++) acc2[i][j] <= '0;
      end
    end else begin
      acc2[0][0] <= acc2[0][0] + if2.A_out[0] * if2.B_out[0];
      acc2[0][1] <= acc2[0][1] + a_pipe[0]    * if2.B_out[1];
      acc2[1][0] <= acc2[1][0] + if2.A_out[1] * b_pipe[0];
      acc2[1][1] <= acc2[1][1] + a_pipe[1]    * b_pipe[1];
      a_pipe[0]  <= if2.A_out[0];
      a_pipe[1]  <= if2.A_out[1];
      b_pipe[0]  <= if2.B_out[0];
      b_pipe[1]  <= if2.B_out[1];
    end
  end

  always_ff @(posedge clk) begin
    if (if1.array_reset) acc1 <= '0;
    else                 acc1 <= acc1 + if1.A_out[0] * if1.B_out[0];
  end

  int n_checks = 0;
  int n_errors = 0;
  logic [4*W-1:0] exp_q[$];

  function automatic logic [1:0][1:0][W-1:0] m2(input logic [W-1:0] a, b, c, d);
    m2[0][0] = a; m2[0][1] = b; m2[1][0] = c; m2[1][1] = d;
  endfunction

  function automatic logic [1:0][W-1:0] v2(input logic [W-1:0] x0, x1);
    v2[0] = x0; v2[1] = x1;
  endfunction

  function automatic logic [4*W-1:0] out2();
    out2 = {acc2[0][0], acc2[0][1], acc2[1][0], acc2[1][1]};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  // Drives start for one cycle from the current IDLE cycle, then waits (bounded)
  // for done. Returns cycles from accept to done, or 0 if done never came.
  task automatic run2(input logic [1:0][1:0][W-1:0] a, input logic [1:0][1:0][W-1:0] b,
                      output int lat);
    lat = 0;
    if2.A_mat = a;
    if2.B_mat = b;
    if2.start = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if2.start = 1'b0;
      #1;
      if (if2.done === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    if2.start = 1'b1; if2.A_mat = '0; if2.B_mat = '0;
    if1.start = 1'b1; if1.A_mat = '0; if1.B_mat = '0;
    tick(); tick(); #1;
    n_checks++;
    if ({if2.ready, if2.busy, if2.done, if2.array_reset} !== 4'b0001) begin
      n_errors++;
      $display("FAIL reset_status: got %b exp 0001", {if2.ready, if2.busy, if2.done, if2.array_reset});
    end
    n_checks++;
    if ({if2.A_out, if2.B_out} !== '0) begin
      n_errors++;
      $display("FAIL reset_streams: got %h exp 0", {if2.A_out, if2.B_out});
    end
    tick();
    rst = 1'b0; if2.start = 1'b0; if1.start = 1'b0;
    #1;
    n_checks++;
    if ({if2.ready, if2.array_reset, if2.busy, st2} !== {3'b100, 3'd0}) begin
      n_errors++;
      $display("FAIL post_reset: got ready/ar/busy/state %b exp 100000", {if2.ready, if2.array_reset, if2.busy, st2});
    end
  endtask

  task automatic test_basic();
    logic [4*W-1:0] e;
    exp_q.push_back({v2(1, 0), v2(5, 0)});
    exp_q.push_back({v2(2, 3), v2(7, 6)});
    exp_q.push_back({v2(0, 4), v2(0, 8)});
    exp_q.push_back('0);
    exp_q.push_back('0);
    if2.A_mat = m2(1, 2, 3, 4);
    if2.B_mat = m2(5, 6, 7, 8);
    if2.start = 1'b1;
    #1;
    n_checks++;
    if (if2.ready !== 1'b1) begin
      n_errors++;
      $display("FAIL basic_ready_c0: got %b exp 1", if2.ready);
    end
    tick(); if2.start = 1'b0; #1;
    n_checks++;
    if ({if2.array_reset, if2.busy, if2.ready, st2} !== {3'b110, 3'd1}) begin
      n_errors++;
      $display("FAIL basic_clear_c1: got ar/busy/ready/state %b exp 110001", {if2.array_reset, if2.busy, if2.ready, st2});
    end
    for (int c = 2; c <= 6; c++) begin
      tick(); #1;
      e = exp_q.pop_front();
      n_checks++;
      if ({if2.A_out, if2.B_out} !== e || if2.busy !== 1'b1 || if2.array_reset !== 1'b0) begin
        n_errors++;
        $display("FAIL basic_stream_c%0d: got %h busy %b ar %b exp %h busy 1 ar 0",
                 c, {if2.A_out, if2.B_out}, if2.busy, if2.array_reset, e);
      end
    end
    tick(); #1;
    n_checks++;
    if ({if2.done, if2.ready, if2.busy} !== 3'b100) begin
      n_errors++;
      $display("FAIL basic_done_c7: got done/ready/busy %b exp 100", {if2.done, if2.ready, if2.busy});
    end
    n_checks++;
    if (out2() !== {32'd19, 32'd22, 32'd43, 32'd50}) begin
      n_errors++;
      $display("FAIL basic_product: got %h exp 19,22,43,50", out2());
    end
    tick(); #1;
    n_checks++;
    if ({if2.done, if2.ready} !== 2'b01) begin
      n_errors++;
      $display("FAIL basic_idle_c8: got done/ready %b exp 01", {if2.done, if2.ready});
    end
  endtask

  task automatic test_start_hold();
    int n_ready;
    int n_done;
    n_ready = 0;
    n_done  = 0;
    if2.A_mat = m2(1, 2, 3, 4);
    if2.B_mat = m2(5, 6, 7, 8);
    if2.start = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      tick();
      if2.A_mat = m2(2, 0, 0, 2);
      if (c == 10) if2.start = 1'b0;
      #1;
      if (c <= 9 && if2.ready === 1'b1) n_ready++;
      if (if2.done === 1'b1) n_done++;
      if (c == 7) begin
        n_checks++;
        if (if2.done !== 1'b1 || out2() !== {32'd19, 32'd22, 32'd43, 32'd50}) begin
          n_errors++;
          $display("FAIL hold_first_product: got done %b out %h exp done 1 out 19,22,43,50", if2.done, out2());
        end
      end
      if (c == 8) begin
        n_checks++;
        if (if2.ready !== 1'b1) begin
          n_errors++;
          $display("FAIL hold_reaccept_c8: got ready %b exp 1", if2.ready);
        end
      end
      if (c == 9) begin
        n_checks++;
        if (if2.array_reset !== 1'b1 || st2 !== 3'd1) begin
          n_errors++;
          $display("FAIL hold_clear_c9: got ar %b state %0d exp ar 1 state 1", if2.array_reset, st2);
        end
      end
      if (c == 15) begin
        n_checks++;
        if (if2.done !== 1'b1 || out2() !== {32'd10, 32'd12, 32'd14, 32'd16}) begin
          n_errors++;
          $display("FAIL hold_second_product: got done %b out %h exp done 1 out 10,12,14,16", if2.done, out2());
        end
      end
    end
    n_checks++;
    if (n_ready != 1 || n_done != 2) begin
      n_errors++;
      $display("FAIL hold_counts: got ready %0d done %0d exp ready 1 done 2", n_ready, n_done);
    end
  endtask

  task automatic test_mid_reset();
    int n_done;
    int lat;
    n_done = 0;
    if2.A_mat = m2(1, 2, 3, 4);
    if2.B_mat = m2(5, 6, 7, 8);
    if2.start = 1'b1;
    tick(); if2.start = 1'b0;
    tick();
    tick(); rst = 1'b1; #1;
    n_checks++;
    if ({if2.array_reset, if2.ready, if2.busy, if2.A_out, if2.B_out} !== {3'b100, {(4*W){1'b0}}}) begin
      n_errors++;
      $display("FAIL midreset_c3: got ar/ready/busy %b streams %h exp 100 and 0",
               {if2.array_reset, if2.ready, if2.busy}, {if2.A_out, if2.B_out});
    end
    tick(); rst = 1'b0; #1;
    n_checks++;
    if ({if2.ready, if2.done, if2.A_out, if2.B_out} !== {2'b10, {(4*W){1'b0}}}) begin
      n_errors++;
      $display("FAIL midreset_c4: got ready/done %b streams %h exp 10 and 0",
               {if2.ready, if2.done}, {if2.A_out, if2.B_out});
    end
    for (int c = 5; c <= 12; c++) begin
      tick(); #1;
      if (if2.done === 1'b1 || if2.busy === 1'b1) n_done++;
    end
    n_checks++;
    if (n_done != 0) begin
      n_errors++;
      $display("FAIL midreset_no_done: got %0d active cycles exp 0", n_done);
    end
    run2(m2(1, 1, 1, 1), m2(1, 2, 3, 4), lat);
    n_checks++;
    if (lat != 7 || out2() !== {32'd4, 32'd6, 32'd4, 32'd6}) begin
      n_errors++;
      $display("FAIL midreset_rerun: got latency %0d out %h exp latency 7 out 4,6,4,6", lat, out2());
    end
    tick();
  endtask

  task automatic test_wrap();
    int lat;
    run2(m2(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF), m2(1, 0, 0, 1), lat);
    n_checks++;
    if (lat != 7 || out2() !== {4{32'hFFFFFFFF}}) begin
      n_errors++;
      $display("FAIL wrap_identity: got latency %0d out %h exp latency 7 out all ffffffff", lat, out2());
    end
    tick();
    run2(m2(32'h10000, 32'h10000, 32'h10000, 32'h10000),
         m2(32'h10000, 32'h10000, 32'h10000, 32'h10000), lat);
    n_checks++;
    if (lat != 7 || out2() !== '0) begin
      n_errors++;
      $display("FAIL wrap_modulo: got latency %0d out %h exp latency 7 out 0", lat, out2());
    end
    tick();
  endtask

  task automatic test_n1();
    if1.A_mat = W'(7);
    if1.B_mat = W'(6);
    if1.start = 1'b1;
    #1;
    n_checks++;
    if (if1.ready !== 1'b1) begin
      n_errors++;
      $display("FAIL n1_ready_c0: got %b exp 1", if1.ready);
    end
    tick(); if1.start = 1'b0; #1;
    n_checks++;
    if (if1.array_reset !== 1'b1) begin
      n_errors++;
      $display("FAIL n1_clear_c1: got ar %b exp 1", if1.array_reset);
    end
    tick(); #1;
    n_checks++;
    if (if1.A_out !== W'(7) || if1.B_out !== W'(6) || st1 !== 3'd2) begin
      n_errors++;
      $display("FAIL n1_feed_c2: got A %0d B %0d state %0d exp A 7 B 6 state 2", if1.A_out, if1.B_out, st1);
    end
    tick(); #1;
    n_checks++;
    if (if1.A_out !== '0 || if1.B_out !== '0 || st1 !== 3'd3 || if1.done !== 1'b0) begin
      n_errors++;
      $display("FAIL n1_drain_c3: got A %0d B %0d state %0d done %b exp 0 0 3 0", if1.A_out, if1.B_out, st1, if1.done);
    end
    tick(); #1;
    n_checks++;
    if (if1.done !== 1'b1 || acc1 !== W'(42)) begin
      n_errors++;
      $display("FAIL n1_done_c4: got done %b out %0d exp done 1 out 42", if1.done, acc1);
    end
    tick(); #1;
    n_checks++;
    if (if1.ready !== 1'b1 || if1.done !== 1'b0) begin
      n_errors++;
      $display("FAIL n1_idle_c5: got ready %b done %b exp 1 0", if1.ready, if1.done);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_start_hold();
    test_mid_reset();
    test_wrap();
    test_n1();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
